// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out an amount with 5/2/1-unit coins, one coin
// per handshake with the coin mechanism, with an idle gap and an ack watchdog.
module change_dispenser #(
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       eject_ack,
  output logic       eject_coin5,
  output logic       eject_coin2,
  output logic       eject_coin1,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [7:0] coin_count
);

  // Parameters below 1 behave as 1 (one cycle in GAP / one cycle of ack wait).
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [AW-1:0] ACK_LAST = AW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      remaining_reg, remaining_next;
  logic [7:0]      coin_count_reg, coin_count_next;
  logic [2:0]      coin_sel_reg, coin_sel_next;   // one-hot: bit2=5, bit1=2, bit0=1
  logic [GW-1:0]   gap_cnt_reg, gap_cnt_next;
  logic [AW-1:0]   ack_cnt_reg, ack_cnt_next;
  logic [2:0]      eject_vec;
  logic [7:0]      value_terms [3];
  logic [7:0]      coin_value;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_coin
      localparam logic [7:0] VAL = (gi == 2) ? 8'd5 : ((gi == 1) ? 8'd2 : 8'd1);
      assign eject_vec[gi]   = (state_reg == EJECT) && coin_sel_reg[gi];
      assign value_terms[gi] = coin_sel_reg[gi] ? VAL : 8'd0;
    end
  endgenerate

  assign coin_value = value_terms[0] | value_terms[1] | value_terms[2];

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    coin_count_next = coin_count_reg;
    coin_sel_next   = coin_sel_reg;
    gap_cnt_next    = gap_cnt_reg;
    ack_cnt_next    = ack_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          remaining_next  = amount;
          coin_count_next = 8'd0;
          state_next      = (amount != 8'd0) ? SELECT : DONE;
        end
      end
      SELECT: begin
        if (remaining_reg >= 8'd5)      coin_sel_next = 3'b100;
        else if (remaining_reg >= 8'd2) coin_sel_next = 3'b010;
        else                            coin_sel_next = 3'b001;
        ack_cnt_next = '0;
        state_next   = EJECT;
      end
      EJECT: begin
        // An ack on the last watchdog cycle still counts as a good ejection.
        if (eject_ack) begin
          remaining_next  = remaining_reg - coin_value;
          coin_count_next = coin_count_reg + 8'd1;
          gap_cnt_next    = '0;
          state_next      = (remaining_reg == coin_value) ? DONE : GAP;
        end else if (ack_cnt_reg == ACK_LAST) begin
          state_next = FAULT;
        end else begin
          ack_cnt_next = ack_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = SELECT;
        else                         gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      remaining_reg  <= 8'd0;
      coin_count_reg <= 8'd0;
      coin_sel_reg   <= 3'b000;
      gap_cnt_reg    <= '0;
      ack_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      coin_count_reg <= coin_count_next;
      coin_sel_reg   <= coin_sel_next;
      gap_cnt_reg    <= gap_cnt_next;
      ack_cnt_reg    <= ack_cnt_next;
    end
  end

  assign eject_coin5 = eject_vec[2];
  assign eject_coin2 = eject_vec[1];
  assign eject_coin1 = eject_vec[0];
  assign busy        = (state_reg == SELECT) || (state_reg == EJECT) ||
                       (state_reg == GAP)    || (state_reg == DONE);
  assign done        = (state_reg == DONE);
  assign fault       = (state_reg == FAULT);
  assign remaining   = remaining_reg;
  assign coin_count  = coin_count_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: acts as the coin mechanism and compares every
// payout against a greedy coin breakdown computed with plain arithmetic.
module tb_change_dispenser;

  localparam int GAP  = 5;
  localparam int ACKT = 40;

  logic       clk = 1'b0;
  logic       rst, start, eject_ack;
  logic [7:0] amount;
  logic       eject_coin5, eject_coin2, eject_coin1, busy, done, fault;
  logic [7:0] remaining, coin_count;

  int vectors     = 0;
  int miscompares = 0;

  change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKT)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .eject_ack(eject_ack),
    .eject_coin5(eject_coin5), .eject_coin2(eject_coin2), .eject_coin1(eject_coin1),
    .busy(busy), .done(done), .fault(fault),
    .remaining(remaining), .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int eject_sum();
    return int'(eject_coin5) + int'(eject_coin2) + int'(eject_coin1);
  endfunction

  function automatic int eject_val();
    return eject_coin5 ? 5 : (eject_coin2 ? 2 : (eject_coin1 ? 1 : 0));
  endfunction

  // One full transaction, with the bench answering each coin request after ack_delay cycles.
  task automatic run_txn(input int a, input int ack_delay, input bit inject);
    int  exp_q[$];
    int  obs_q[$];
    int  paid, low_run, hold, cur_val;
    bit  finished, ack_pending;
    for (int i = 0; i < a / 5; i++)       exp_q.push_back(5);
    for (int i = 0; i < (a % 5) / 2; i++) exp_q.push_back(2);
    if ((a % 5) % 2 == 1)                 exp_q.push_back(1);

    @(negedge clk); start = 1'b1; amount = 8'(a);
    @(negedge clk); start = 1'b0; amount = 8'($urandom);
    if (a == 0) begin
      chk("zero_done", done, 1);
      chk("zero_eject", eject_sum(), 0);
      chk("zero_count", coin_count, 0);
      @(negedge clk);
      chk("zero_done_drop", done, 0);
      chk("zero_idle_busy", busy, 0);
      $display("txn amount=%0d coins=0 delay=%0d", a, ack_delay);
      return;
    end

    paid = 0; low_run = 0; hold = 0; cur_val = 0; finished = 1'b0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      ack_pending = eject_ack;
      eject_ack   = 1'b0;
      chk("onehot", (eject_sum() <= 1) ? 1 : 0, 1);
      chk("busy", busy, 1);
      if (ack_pending) chk("drop_after_ack", eject_sum(), 0);
      if (done) begin
        finished = 1'b1;
      end else if (eject_sum() != 0) begin
        if (hold == 0) begin
          cur_val = eject_val();
          obs_q.push_back(cur_val);
          chk("gap_len", low_run, (obs_q.size() == 1) ? 1 : GAP + 1);
          chk("remaining_mid", remaining, a - paid);
          chk("count_mid", coin_count, obs_q.size() - 1);
        end
        hold++;
        if (hold == ack_delay + 1) begin
          eject_ack = 1'b1;
          paid += cur_val;
        end
        low_run = 0;
      end else begin
        hold = 0;
        low_run++;
      end
      if (inject && cyc == 2) begin start = 1'b1; amount = 8'd7; end
      else start = 1'b0;
      if (!finished) @(negedge clk);
    end
    start = 1'b0;
    if (!finished) chk("txn_timeout", 0, 1);
    chk("coin_total", obs_q.size(), exp_q.size());
    chk("count_end", coin_count, exp_q.size() % 256);
    chk("remaining_end", remaining, 0);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("coin_seq", obs_q[i], exp_q[i]);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    $display("txn amount=%0d coins=%0d delay=%0d inject=%0d", a, obs_q.size(), ack_delay, inject);
  endtask

  initial begin
    int cnt;
    rst = 1'b0; start = 1'b0; eject_ack = 1'b0; amount = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_state", {eject_coin5, eject_coin2, eject_coin1, busy, done, fault, remaining, coin_count}, 0);
    rst = 1'b1;

    run_txn(8, 3, 1'b0);
    run_txn(0, 0, 1'b0);
    run_txn(3, 1, 1'b1);
    run_txn(255, 0, 1'b0);

    // Ack never comes: watchdog must fault with state frozen.
    @(negedge clk); start = 1'b1; amount = 8'd4;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * ACKT + 10; i++) begin
      if (fault) break;
      if (eject_coin2) cnt++;
      chk("t_other_lines", eject_coin5 | eject_coin1, 0);
      @(negedge clk);
    end
    chk("t_eject_len", cnt, ACKT);
    chk("t_fault", fault, 1);
    chk("t_coin2_drop", eject_coin2, 0);
    chk("t_remaining", remaining, 4);
    chk("t_count", coin_count, 0);
    chk("t_busy", busy, 0);
    start = 1'b1; amount = 8'd5; eject_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("t_sticky", {fault, busy, eject_coin5, eject_coin2, eject_coin1}, 5'b10000);
    start = 1'b0; eject_ack = 1'b0;
    $display("txn amount=4 timeout eject_cycles=%0d", cnt);
    rst = 1'b0;
    @(negedge clk);
    chk("fault_cleared", fault, 0);
    rst = 1'b1;

    // Reset while a 5-unit coin is being requested.
    @(negedge clk); start = 1'b1; amount = 8'd12;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!eject_coin5 && cnt < 20) begin @(negedge clk); cnt++; end
    chk("r_coin5_seen", eject_coin5, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("r_all_zero", {eject_coin5, eject_coin2, eject_coin1, busy, done, fault, remaining, coin_count}, 0);
    start = 1'b1; amount = 8'd0; eject_ack = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("r_no_eject", eject_sum(), 0);
    chk("r_done", done, 1);
    start = 1'b0; eject_ack = 1'b0;
    @(negedge clk);
    chk("r_idle", busy, 0);
    $display("txn reset mid-eject recovered");

    for (int n = 0; n < 12; n++)
      run_txn(int'($urandom_range(0, 40)), int'($urandom_range(0, 4)), n[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles between consecutive coin ejections.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 1000, meaning maximum cycles to wait for eject_ack before faulting.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1, single-cycle request to dispense amount.
REQ-006 SHALL have port amount, input, 8, change value in credit units, sampled only with an accepted start.
REQ-007 SHALL have port eject_ack, input, 1, from the coin mechanism, meaning the requested coin has been released.
REQ-008 SHALL have port eject_coin5, output, 1, request to release one 5-unit coin.
REQ-009 SHALL have port eject_coin2, output, 1, request to release one 2-unit coin.
REQ-010 SHALL have port eject_coin1, output, 1, request to release one 1-unit coin.
REQ-011 SHALL have port busy, output, 1, high while a transaction is in progress.
REQ-012 SHALL have port done, output, 1, single-cycle pulse when a transaction completes.
REQ-013 SHALL have port fault, output, 1, sticky indicator of an ack timeout.
REQ-014 SHALL have port remaining, output, 8, change still owed in the current transaction.
REQ-015 SHALL have port coin_count, output, 8, coins ejected in the current transaction.

Function
REQ-016 SHALL implement states IDLE, SELECT, EJECT, GAP, DONE, FAULT.
REQ-017 SHALL, in IDLE with start=1 and amount>0, load remaining<=amount, clear coin_count<=0, and go to SELECT.
REQ-018 SHALL, in IDLE with start=1 and amount=0, go directly to DONE with no eject asserted.
REQ-019 SHALL ignore start in every state except IDLE.
REQ-020 SHALL, in SELECT for one cycle, choose the coin greedily: 5 if remaining>=5, else 2 if remaining>=2, else 1; then go to EJECT.
REQ-021 SHALL, in EJECT, hold exactly the chosen eject line high, keep the other two low, and drop it in the cycle after eject_ack=1 is sampled.
REQ-022 SHALL, on sampling eject_ack in EJECT, subtract the coin value from remaining, increment coin_count (wrapping at 255), then go to DONE if the new remaining is 0, otherwise to GAP.
REQ-023 SHALL, in GAP, wait exactly GAP_CYCLES cycles, then go to SELECT.
REQ-024 SHALL count cycles spent in EJECT and go to FAULT if the count reaches ACK_TIMEOUT without eject_ack; remaining and coin_count SHALL freeze at their current values.
REQ-025 SHALL, in DONE, assert done for exactly one cycle and then return to IDLE.
REQ-026 SHALL drive busy=1 in SELECT, EJECT, GAP and DONE, and busy=0 in IDLE and FAULT.
REQ-027 SHALL hold fault=1 and all eject lines low in FAULT, which SHALL be left only by reset.
REQ-028 SHALL ignore eject_ack in every state except EJECT.
REQ-029 SHALL never assert more than one eject line in the same cycle.
REQ-030 SHALL never underflow remaining; the greedy rule guarantees coin value <= remaining.

Reset
REQ-031 SHALL, when rst=0 at a clock edge, go to IDLE and clear all eject lines, busy, done, fault, remaining and coin_count to 0, including mid-transaction.
REQ-032 SHALL produce no ejection on the first cycle after reset release, even if start or eject_ack is high.

Verification
REQ-033 SHALL cover: start with amount=8, ack 3 cycles after each request -> coin5, coin2, coin1 in order; GAP_CYCLES between them; done pulse; coin_count=3; remaining=0.
REQ-034 SHALL cover: start with amount=0 -> done one cycle later; no eject line asserted; coin_count=0.
REQ-035 SHALL cover: start with amount=4, eject_ack never asserted -> fault=1 after ACK_TIMEOUT cycles in EJECT; eject_coin2 drops; remaining=4; busy=0.
REQ-036 SHALL cover: second start with amount=7 during an amount=3 transaction -> ignored; exactly coin2 then coin1 issued.
REQ-037 SHALL cover: rst=0 asserted while eject_coin5 is high -> next cycle all outputs are 0 and the FSM is in IDLE.
REQ-038 SHALL cover: amount=255 with immediate acks -> 51 coin5 ejections; coin_count=51; no other coin lines asserted.
